calc1_port_responder: RTL and testbench
=======================================

Name: calc1_port_responder

Overview:
Cycle-accurate responder for one calc1 request port. It is the receiving end of the cmd/data request protocol that the bench driver generates. It accepts a command with operand1, then operand2 on the following cycle, computes the result, and returns a one-cycle response code plus result data after a programmable delay. It is used as a golden port model for comparison against the DUT and as a stand-in responder when bringing up the driver in isolation.

Parameters:
DATA_W, 32, operand/result width (bits).
RESP_DELAY, 3, cycles from operand2 capture edge to response edge; legal range 1..15.

Ports:
c_clk  input  1  single clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
req_cmd_in  input  4  command: 0 NOP, 1 ADD, 2 SUB, 5 LSH, 6 RSH; all other values are invalid.
req_data_in  input  DATA_W  operand1 in the command cycle, operand2 in the next cycle.
out_resp  output  2  0 none, 1 success, 2 overflow/underflow, 3 invalid command.
out_data  output  DATA_W  result; valid only while out_resp==1.
busy  output  1  high from the command-capture edge until the response cycle ends.
protocol_err  output  1  one-cycle pulse when a non-NOP command arrives while busy.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; out_resp=0, out_data=0, busy=0, protocol_err=0; the counter and operand/command registers clear. Assertion mid-operation aborts the operation and no response is issued.
- FSM states: IDLE, OP2, WAIT, RESP.
- IDLE:
  - req_cmd_in!=0 at edge T: capture cmd and operand1 (req_data_in), set busy=1, go to OP2.
  - req_cmd_in==0 (NOP): stay in IDLE. Data is ignored.
- OP2 (edge T+1):
  - Capture operand2 from req_data_in. req_cmd_in is ignored on this cycle; it must be NOP, and no error is flagged either way.
  - Compute the result and code into registers.
  - Load counter=RESP_DELAY-1. Go to WAIT, or directly to RESP if RESP_DELAY==1.
- WAIT: decrement the counter each cycle; go to RESP when the counter reaches 0.
- RESP:
  - out_resp and out_data are registered and driven for exactly one cycle, starting at edge T+1+RESP_DELAY.
  - The next edge returns out_resp=0, out_data=0, busy=0, state=IDLE.
  - A command presented in the RESP cycle is flagged as protocol_err. It is not accepted.
- Arithmetic:
  - All operations are unsigned and DATA_W wide.
  - ADD: sum=op1+op2. A carry-out gives code 2 with data 0; otherwise code 1 with the sum.
  - SUB: op2>op1 gives code 2 with data 0; otherwise code 1 with op1-op2.
  - LSH: op1 << op2[4:0] (log2(DATA_W) LSBs). Code 1, even when bits are shifted out.
  - RSH: logical op1 >> op2[4:0]. Code 1.
  - Invalid command: operand2 is still consumed. Code 3 with data 0, same latency as valid commands.
- Busy violations: a non-NOP command while busy (OP2 excluded) pulses protocol_err for 1 cycle and is dropped. The operation in flight is unaffected.
- out_data is 0 whenever out_resp!=1.

Test Plan:
1. Reset, then ADD 0xFFFF0000 followed by 0x0000FFFF, RESP_DELAY=3 -> out_resp=1 and out_data=0xFFFFFFFF for exactly one cycle, starting 4 edges after the command edge; busy is high for 5 cycles.
2. ADD 0x55555555 + 0x99999999 -> resp 1, data 0xEEEEEEEE. Then ADD 0xFFFFFFFF + 0x00000001 -> resp 2, data 0.
3. SUB 0x00000005 - 0x00000005 -> resp 1, data 0. Then SUB 0x00000000 - 0x00000001 -> resp 2, data 0.
4. LSH 0x00000001 by 0x00000021 -> resp 1, data 0x00000002 (only low 5 bits used). Then RSH 0x80000000 by 31 -> resp 1, data 0x00000001.
5. Command 3 with operands 0x1234/0x5678 -> resp 3, data 0 at normal latency. Then ADD issued during WAIT -> protocol_err pulses for 1 cycle, and only the original response appears.
6. Assert reset two cycles after an ADD command edge -> all outputs 0 immediately (asynchronously), and no response appears afterwards. A following ADD 2+3 -> resp 1, data 5.

Source files
------------

// File: rtl/calc1_port_responder.sv
// Golden responder for one calc1 request port: takes cmd+operand1, then operand2,
// and returns a one-cycle response code/result RESP_DELAY edges after operand2 capture.
module calc1_port_responder #(
  parameter int DATA_W     = 32,
  parameter int RESP_DELAY = 3
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [3:0]        req_cmd_in,
  input  logic [DATA_W-1:0] req_data_in,
  output logic [1:0]        out_resp,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              protocol_err
);

  localparam int          SH_W     = $clog2(DATA_W);
  localparam logic [3:0]  CMD_NOP  = 4'd0;
  localparam logic [3:0]  CMD_ADD  = 4'd1;
  localparam logic [3:0]  CMD_SUB  = 4'd2;
  localparam logic [3:0]  CMD_LSH  = 4'd5;
  localparam logic [3:0]  CMD_RSH  = 4'd6;
  localparam logic [1:0]  RESP_OK  = 2'd1;
  localparam logic [1:0]  RESP_OVF = 2'd2;
  localparam logic [1:0]  RESP_INV = 2'd3;
  localparam logic [3:0]  CNT_INIT = 4'(RESP_DELAY - 1);

  typedef enum logic [1:0] {IDLE, OP2, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [DATA_W-1:0] op1_q, op1_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [1:0]        code_q, code_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        out_resp_q, out_resp_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              perr_q, perr_d;

  logic [DATA_W:0]   sum;
  logic [1:0]        alu_code;
  logic [DATA_W-1:0] alu_data;

  // Operand2 is consumed straight off the bus in the OP2 cycle.
  assign sum = {1'b0, op1_q} + {1'b0, req_data_in};

  always_comb begin
    alu_code = RESP_INV;
    alu_data = '0;
    case (cmd_q)
      CMD_ADD: begin
        if (sum[DATA_W]) begin
          alu_code = RESP_OVF;
        end else begin
          alu_code = RESP_OK;
          alu_data = sum[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        if (req_data_in > op1_q) begin
          alu_code = RESP_OVF;
        end else begin
          alu_code = RESP_OK;
          alu_data = op1_q - req_data_in;
        end
      end
      CMD_LSH: begin
        alu_code = RESP_OK;
        alu_data = op1_q << req_data_in[SH_W-1:0];
      end
      CMD_RSH: begin
        alu_code = RESP_OK;
        alu_data = op1_q >> req_data_in[SH_W-1:0];
      end
      default: begin
        alu_code = RESP_INV;
        alu_data = '0;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    op1_d      = op1_q;
    res_d      = res_q;
    code_d     = code_q;
    cnt_d      = cnt_q;
    out_resp_d = 2'd0;
    out_data_d = '0;
    perr_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_cmd_in != CMD_NOP) begin
          cmd_d   = req_cmd_in;
          op1_d   = req_data_in;
          state_d = OP2;
        end
      end
      OP2: begin
        res_d  = alu_data;
        code_d = alu_code;
        cnt_d  = CNT_INIT;
        if (RESP_DELAY == 1) begin
          state_d    = RESP;
          out_resp_d = alu_code;
          out_data_d = alu_data;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        perr_d = (req_cmd_in != CMD_NOP);
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          out_resp_d = code_q;
          out_data_d = res_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        // A command here is flagged and dropped, not queued.
        perr_d  = (req_cmd_in != CMD_NOP);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cmd_q      <= 4'd0;
      op1_q      <= '0;
      res_q      <= '0;
      code_q     <= 2'd0;
      cnt_q      <= 4'd0;
      out_resp_q <= 2'd0;
      out_data_q <= '0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      op1_q      <= op1_d;
      res_q      <= res_d;
      code_q     <= code_d;
      cnt_q      <= cnt_d;
      out_resp_q <= out_resp_d;
      out_data_q <= out_data_d;
      perr_q     <= perr_d;
    end
  end

  assign out_resp     = out_resp_q;
  assign out_data     = out_data_q;
  assign busy         = (state_q != IDLE);
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_calc1_port_responder.sv
// Directed bench for calc1_port_responder at DATA_W=32, RESP_DELAY=3.
module tb_calc1_port_responder;

  logic        c_clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req_cmd_in = 4'd0;
  logic [31:0] req_data_in = 32'd0;
  logic [1:0]  out_resp;
  logic [31:0] out_data;
  logic        busy;
  logic        protocol_err;

  int checks = 0;
  int errors = 0;

  calc1_port_responder #(.DATA_W(32), .RESP_DELAY(3)) dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .req_cmd_in   (req_cmd_in),
    .req_data_in  (req_data_in),
    .out_resp     (out_resp),
    .out_data     (out_data),
    .busy         (busy),
    .protocol_err (protocol_err)
  );

  always #5 c_clk = ~c_clk;

  task automatic step();
    @(posedge c_clk);
    #1;
  endtask

  // Presents cmd/op1 then op2; returns just after the operand2 capture edge.
  task automatic issue_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    req_cmd_in  = cmd;
    req_data_in = a;
    step();
    req_cmd_in  = 4'd0;
    req_data_in = b;
    step();
    req_data_in = 32'd0;
  endtask

  // Waits (bounded) for a response; lat counts edges after the command edge, -1 on timeout.
  task automatic wait_resp(output logic [1:0] resp, output logic [31:0] data, output int lat);
    resp = 2'd0;
    data = 32'd0;
    lat  = -1;
    for (int n = 2; n < 24; n++) begin
      step();
      if (out_resp != 2'd0) begin
        resp = out_resp;
        data = out_data;
        lat  = n;
        break;
      end
    end
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    checks++;
    if ({out_resp, out_data, busy, protocol_err} !== 36'd0) begin
      errors++;
      $display("FAIL reset_outputs: got resp=%0d data=%h busy=%b perr=%b, want all 0",
               out_resp, out_data, busy, protocol_err);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_add_timing();
    int busy_cnt = 0;
    req_cmd_in  = 4'd1;
    req_data_in = 32'hFFFF0000;
    step();
    if (busy) busy_cnt++;
    req_cmd_in  = 4'd0;
    req_data_in = 32'h0000FFFF;
    step();
    if (busy) busy_cnt++;
    req_data_in = 32'd0;
    for (int e = 2; e <= 6; e++) begin
      step();
      if (busy) busy_cnt++;
      checks++;
      if (e == 4) begin
        if (out_resp !== 2'd1 || out_data !== 32'hFFFFFFFF) begin
          errors++;
          $display("FAIL add_resp_edge4: got resp=%0d data=%h, want resp=1 data=ffffffff", out_resp, out_data);
        end
      end else if (out_resp !== 2'd0 || out_data !== 32'd0) begin
        errors++;
        $display("FAIL add_quiet_edge%0d: got resp=%0d data=%h, want resp=0 data=0", e, out_resp, out_data);
      end
    end
    checks++;
    if (busy_cnt != 5) begin
      errors++;
      $display("FAIL add_busy_len: got %0d cycles, want 5", busy_cnt);
    end
  endtask

  task automatic test_add();
    logic [1:0] r; logic [31:0] d; int lat;
    issue_op(4'd1, 32'h55555555, 32'h99999999);
    wait_resp(r, d, lat);
    checks++;
    if (r !== 2'd1 || d !== 32'hEEEEEEEE || lat != 4) begin
      errors++;
      $display("FAIL add_nocarry: got resp=%0d data=%h lat=%0d, want 1 eeeeeeee 4", r, d, lat);
    end
    issue_op(4'd1, 32'hFFFFFFFF, 32'h00000001);
    wait_resp(r, d, lat);
    checks++;
    if (r !== 2'd2 || d !== 32'd0 || lat != 4) begin
      errors++;
      $display("FAIL add_carry: got resp=%0d data=%h lat=%0d, want 2 0 4", r, d, lat);
    end
  endtask

  task automatic test_sub();
    logic [1:0] r; logic [31:0] d; int lat;
    issue_op(4'd2, 32'h5, 32'h5);
    wait_resp(r, d, lat);
    checks++;
    if (r !== 2'd1 || d !== 32'd0 || lat != 4) begin
      errors++;
      $display("FAIL sub_equal: got resp=%0d data=%h lat=%0d, want 1 0 4", r, d, lat);
    end
    issue_op(4'd2, 32'h0, 32'h1);
    wait_resp(r, d, lat);
    checks++;
    if (r !== 2'd2 || d !== 32'd0 || lat != 4) begin
      errors++;
      $display("FAIL sub_under: got resp=%0d data=%h lat=%0d, want 2 0 4", r, d, lat);
    end
    issue_op(4'd2, 32'h10, 32'h3);
    wait_resp(r, d, lat);
    checks++;
    if (r !== 2'd1 || d !== 32'hD || lat != 4) begin
      errors++;
      $display("FAIL sub_plain: got resp=%0d data=%h lat=%0d, want 1 d 4", r, d, lat);
    end
  endtask

  task automatic test_shift();
    logic [1:0] r; logic [31:0] d; int lat;
    issue_op(4'd5, 32'h1, 32'h21);
    wait_resp(r, d, lat);
    checks++;
    if (r !== 2'd1 || d !== 32'h2 || lat != 4) begin
      errors++;
      $display("FAIL lsh_mask: got resp=%0d data=%h lat=%0d, want 1 2 4", r, d, lat);
    end
    issue_op(4'd6, 32'h80000000, 32'd31);
    wait_resp(r, d, lat);
    checks++;
    if (r !== 2'd1 || d !== 32'h1 || lat != 4) begin
      errors++;
      $display("FAIL rsh_31: got resp=%0d data=%h lat=%0d, want 1 1 4", r, d, lat);
    end
    issue_op(4'd5, 32'hC0000001, 32'd4);
    wait_resp(r, d, lat);
    checks++;
    if (r !== 2'd1 || d !== 32'h00000010 || lat != 4) begin
      errors++;
      $display("FAIL lsh_lost_bits: got resp=%0d data=%h lat=%0d, want 1 10 4", r, d, lat);
    end
  endtask

  task automatic test_invalid_and_busy();
    logic [1:0] r; logic [31:0] d; int lat; int extra = 0;
    issue_op(4'd3, 32'h1234, 32'h5678);
    wait_resp(r, d, lat);
    checks++;
    if (r !== 2'd3 || d !== 32'd0 || lat != 4) begin
      errors++;
      $display("FAIL invalid_cmd: got resp=%0d data=%h lat=%0d, want 3 0 4", r, d, lat);
    end
    issue_op(4'd1, 32'd1, 32'd2);
    req_cmd_in  = 4'd1;
    req_data_in = 32'hDEAD;
    step();
    req_cmd_in  = 4'd0;
    req_data_in = 32'd0;
    checks++;
    if (protocol_err !== 1'b1) begin
      errors++;
      $display("FAIL perr_wait_pulse: got %b, want 1", protocol_err);
    end
    step();
    checks++;
    if (protocol_err !== 1'b0 || out_resp !== 2'd0) begin
      errors++;
      $display("FAIL perr_wait_clear: got perr=%b resp=%0d, want 0 0", protocol_err, out_resp);
    end
    req_cmd_in = 4'd2;
    step();
    checks++;
    if (out_resp !== 2'd1 || out_data !== 32'd3) begin
      errors++;
      $display("FAIL busy_orig_resp: got resp=%0d data=%h, want 1 3", out_resp, out_data);
    end
    step();
    req_cmd_in = 4'd0;
    checks++;
    if (protocol_err !== 1'b1 || busy !== 1'b0 || out_resp !== 2'd0) begin
      errors++;
      $display("FAIL perr_resp_cycle: got perr=%b busy=%b resp=%0d, want 1 0 0", protocol_err, busy, out_resp);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_resp != 2'd0 || busy) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL dropped_cmd_quiet: got %0d active cycles, want 0", extra);
    end
  endtask

  task automatic test_reset_abort();
    logic [1:0] r; logic [31:0] d; int lat; int extra = 0;
    issue_op(4'd1, 32'd7, 32'd8);
    step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy_before: got %b, want 1", busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({out_resp, out_data, busy, protocol_err} !== 36'd0) begin
      errors++;
      $display("FAIL abort_async_clear: got resp=%0d data=%h busy=%b perr=%b, want all 0",
               out_resp, out_data, busy, protocol_err);
    end
    #2;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_resp != 2'd0 || busy) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL abort_no_resp: got %0d active cycles, want 0", extra);
    end
    issue_op(4'd1, 32'd2, 32'd3);
    wait_resp(r, d, lat);
    checks++;
    if (r !== 2'd1 || d !== 32'd5 || lat != 4) begin
      errors++;
      $display("FAIL abort_then_add: got resp=%0d data=%h lat=%0d, want 1 5 4", r, d, lat);
    end
  endtask

  initial begin
    test_reset();
    test_add_timing();
    test_add();
    test_sub();
    test_shift();
    test_invalid_and_busy();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
